// File: rtl/bno055_euler_sequencer.sv
// Master sequencer for the BNO055 I2C register engine: boot wait, CHIP_ID check,
// NDOF mode switch, then periodic six-byte Euler bursts published as coherent words.
module bno055_euler_sequencer #(
    parameter int unsigned BOOT_CYCLES = 17500000,
    parameter int unsigned MODE_CYCLES = 500000,
    parameter int unsigned POLL_CYCLES = 250000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_req,
    output logic        o_wr,
    output logic [7:0]  o_addr,
    output logic [7:0]  o_wdata,
    input  logic        i_done,
    input  logic        i_err,
    input  logic [7:0]  i_rdata,
    output logic [15:0] o_heading,
    output logic [15:0] o_roll,
    output logic [15:0] o_pitch,
    output logic        o_valid,
    output logic        o_ready,
    output logic        o_fault
);

    localparam logic [31:0] BOOT_LAST = 32'(BOOT_CYCLES - 1);
    localparam logic [31:0] MODE_LAST = 32'(MODE_CYCLES - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        StBoot, StIdRd, StModeWr, StModeWait, StEulRd, StPublish, StWaitPoll, StFault
    } state_t;

    state_t      r_state, w_state_d;
    logic [31:0] r_timer, w_timer_d;
    logic [31:0] r_poll, w_poll_d;
    logic        r_tick_pend, w_tick_pend_d;
    logic [7:0]  r_retry, w_retry_d;
    logic [2:0]  r_idx, w_idx_d;
    logic [47:0] r_shadow, w_shadow_d;
    logic        r_req, w_req_d;
    logic        r_wr, w_wr_d;
    logic [7:0]  r_addr, w_addr_d;
    logic [7:0]  r_wdata, w_wdata_d;
    logic [15:0] r_heading, w_heading_d;
    logic [15:0] r_roll, w_roll_d;
    logic [15:0] r_pitch, w_pitch_d;
    logic        r_valid, w_valid_d;
    logic        r_ready, w_ready_d;
    logic        r_fault, w_fault_d;
    logic        w_done, w_ok, w_fail, w_poll_tick;

    always_comb begin
        w_state_d     = r_state;
        w_timer_d     = r_timer;
        w_poll_d      = r_poll;
        w_retry_d     = r_retry;
        w_idx_d       = r_idx;
        w_shadow_d    = r_shadow;
        w_req_d       = r_req;
        w_wr_d        = r_wr;
        w_addr_d      = r_addr;
        w_wdata_d     = r_wdata;
        w_heading_d   = r_heading;
        w_roll_d      = r_roll;
        w_pitch_d     = r_pitch;
        w_valid_d     = 1'b0;
        w_ready_d     = r_ready;
        w_fault_d     = r_fault;
        w_done        = i_done & r_req;
        w_ok          = w_done & ~i_err;
        w_fail        = w_done & i_err;
        w_poll_tick   = r_ready && (r_poll == POLL_LAST);
        // At most one tick is ever held while a burst is still in flight.
        w_tick_pend_d = r_tick_pend | w_poll_tick;

        if (r_ready) w_poll_d = w_poll_tick ? 32'd0 : r_poll + 32'd1;
        if (w_done) w_req_d = 1'b0;
        if (w_ok) w_retry_d = 8'd0;

        case (r_state)
            StBoot: begin
                if (r_timer == BOOT_LAST) begin
                    w_timer_d = 32'd0;
                    w_state_d = StIdRd;
                end else begin
                    w_timer_d = r_timer + 32'd1;
                end
            end
            StIdRd: begin
                if (!r_req) begin
                    w_req_d   = 1'b1;
                    w_wr_d    = 1'b0;
                    w_addr_d  = 8'h00;
                    w_wdata_d = 8'h00;
                end
                if (w_ok) w_state_d = (i_rdata == 8'hA0) ? StModeWr : StFault;
            end
            StModeWr: begin
                if (!r_req) begin
                    w_req_d   = 1'b1;
                    w_wr_d    = 1'b1;
                    w_addr_d  = 8'h3D;
                    w_wdata_d = 8'h0C;
                end
                if (w_ok) w_state_d = StModeWait;
            end
            StModeWait: begin
                if (r_timer == MODE_LAST) begin
                    w_timer_d     = 32'd0;
                    w_ready_d     = 1'b1;
                    w_poll_d      = 32'd0;
                    w_tick_pend_d = 1'b0;
                    w_idx_d       = 3'd0;
                    w_state_d     = StEulRd;
                end else begin
                    w_timer_d = r_timer + 32'd1;
                end
            end
            StEulRd: begin
                if (!r_req) begin
                    w_req_d   = 1'b1;
                    w_wr_d    = 1'b0;
                    w_addr_d  = 8'h1A + {5'd0, r_idx};
                    w_wdata_d = 8'h00;
                end
                if (w_ok) begin
                    w_shadow_d[{r_idx, 3'b000} +: 8] = i_rdata;
                    if (r_idx == 3'd5) w_state_d = StPublish;
                    else w_idx_d = r_idx + 3'd1;
                end
            end
            StPublish: begin
                w_heading_d = r_shadow[15:0];
                w_roll_d    = r_shadow[31:16];
                w_pitch_d   = r_shadow[47:32];
                w_valid_d   = 1'b1;
                if (w_tick_pend_d) begin
                    w_tick_pend_d = 1'b0;
                    w_idx_d       = 3'd0;
                    w_state_d     = StEulRd;
                end else begin
                    w_state_d = StWaitPoll;
                end
            end
            StWaitPoll: begin
                if (w_tick_pend_d) begin
                    w_tick_pend_d = 1'b0;
                    w_idx_d       = 3'd0;
                    w_state_d     = StEulRd;
                end
            end
            default: w_state_d = StFault;
        endcase

        if (w_fail) begin
            if (r_retry == RETRY_MAX) w_state_d = StFault;
            else w_retry_d = r_retry + 8'd1;
        end

        if (w_state_d == StFault) begin
            w_req_d   = 1'b0;
            w_ready_d = 1'b0;
            w_fault_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StBoot;
            r_timer     <= 32'd0;
            r_poll      <= 32'd0;
            r_tick_pend <= 1'b0;
            r_retry     <= 8'd0;
            r_idx       <= 3'd0;
            r_shadow    <= 48'd0;
            r_req       <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= 8'd0;
            r_wdata     <= 8'd0;
            r_heading   <= 16'd0;
            r_roll      <= 16'd0;
            r_pitch     <= 16'd0;
            r_valid     <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_timer     <= w_timer_d;
            r_poll      <= w_poll_d;
            r_tick_pend <= w_tick_pend_d;
            r_retry     <= w_retry_d;
            r_idx       <= w_idx_d;
            r_shadow    <= w_shadow_d;
            r_req       <= w_req_d;
            r_wr        <= w_wr_d;
            r_addr      <= w_addr_d;
            r_wdata     <= w_wdata_d;
            r_heading   <= w_heading_d;
            r_roll      <= w_roll_d;
            r_pitch     <= w_pitch_d;
            r_valid     <= w_valid_d;
            r_ready     <= w_ready_d;
            r_fault     <= w_fault_d;
        end
    end

    assign o_req     = r_req;
    assign o_wr      = r_wr;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_heading = r_heading;
    assign o_roll    = r_roll;
    assign o_pitch   = r_pitch;
    assign o_valid   = r_valid;
    assign o_ready   = r_ready;
    assign o_fault   = r_fault;

endmodule

// File: tb/tb_bno055_euler_sequencer.sv
// Directed bench for bno055_euler_sequencer with a behavioural I2C engine that
// answers requests after a configurable latency and can inject NACKs.
module tb_bno055_euler_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_req, o_wr, o_valid, o_ready, o_fault;
    logic [7:0]  o_addr, o_wdata;
    logic        i_done = 1'b0, i_err = 1'b0;
    logic [7:0]  i_rdata = 8'h00;
    logic [15:0] o_heading, o_roll, o_pitch;

    bno055_euler_sequencer #(
        .BOOT_CYCLES(100), .MODE_CYCLES(50), .POLL_CYCLES(400), .MAX_RETRY(3)
    ) dut (
        .i_clk(clk), .i_rst(rst), .o_req(o_req), .o_wr(o_wr), .o_addr(o_addr),
        .o_wdata(o_wdata), .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
        .o_heading(o_heading), .o_roll(o_roll), .o_pitch(o_pitch),
        .o_valid(o_valid), .o_ready(o_ready), .o_fault(o_fault)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model configuration
    int          lat = 10;
    logic [7:0]  chip = 8'hA0;
    logic [7:0]  eul [6];
    logic [7:0]  err_addr = 8'hFF;
    int          err_cnt = 0;

    // Monitor state
    logic [16:0] log_q [$];
    int          rise_cyc_q [$];
    int          rise1a_q [$];
    int          valid_q [$];
    int          valid_cnt = 0;
    int          stab_err = 0;
    int          req_in_fault = 0;
    int          rel_cyc = 0;

    initial begin : engine
        bit          busy;
        int          cnt;
        logic        prev_req;
        logic [16:0] prev_cmd;
        busy = 0; cnt = 0; prev_req = 0; prev_cmd = '0;
        forever begin
            @(negedge clk);
            i_done = 1'b0;
            i_err  = 1'b0;
            if (rst) begin
                busy = 0;
                prev_req = 0;
            end else begin
                if (o_valid) begin
                    valid_cnt++;
                    valid_q.push_back(cyc);
                end
                if (o_req && o_fault) req_in_fault++;
                if (o_req && !prev_req) begin
                    log_q.push_back({o_wr, o_addr, o_wdata});
                    rise_cyc_q.push_back(cyc);
                    if (!o_wr && o_addr == 8'h1A) rise1a_q.push_back(cyc);
                end else if (o_req && prev_req && {o_wr, o_addr, o_wdata} != prev_cmd) begin
                    stab_err++;
                end
                prev_req = o_req;
                prev_cmd = {o_wr, o_addr, o_wdata};
                if (o_req && !busy) begin
                    busy = 1;
                    cnt  = lat;
                end
                if (busy) begin
                    if (cnt == 0) begin
                        busy   = 0;
                        i_done = 1'b1;
                        if (o_addr == err_addr && err_cnt > 0) begin
                            i_err = 1'b1;
                            err_cnt--;
                        end
                        if (o_wr) i_rdata = 8'h00;
                        else if (o_addr == 8'h00) i_rdata = chip;
                        else if (o_addr >= 8'h1A && o_addr <= 8'h1F) i_rdata = eul[o_addr - 8'h1A];
                        else i_rdata = 8'h00;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    task automatic start_run(input int latency, input logic [7:0] id);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        log_q.delete(); rise_cyc_q.delete(); rise1a_q.delete(); valid_q.delete();
        valid_cnt = 0; stab_err = 0; req_in_fault = 0;
        lat = latency; chip = id; err_addr = 8'hFF; err_cnt = 0;
        eul[0] = 8'h10; eul[1] = 8'h05; eul[2] = 8'hF0;
        eul[3] = 8'hFF; eul[4] = 8'h20; eul[5] = 8'h00;
        @(negedge clk);
        #2 rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_valid(input int n, input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (valid_cnt >= n) begin ok = 1; break; end
        end
    endtask

    task automatic wait_fault(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (o_fault) begin ok = 1; break; end
        end
    endtask

    function automatic int count_addr(input logic [7:0] a);
        int n = 0;
        foreach (log_q[i]) if (log_q[i][15:8] == a) n++;
        return n;
    endfunction

    task test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_req, o_wr, o_addr, o_wdata} !== 18'd0) begin
            errors++; $display("FAIL reset_req: got %b/%b/%h/%h want 0", o_req, o_wr, o_addr, o_wdata);
        end
        checks++;
        if ({o_valid, o_ready, o_fault, o_heading, o_roll, o_pitch} !== 51'd0) begin
            errors++; $display("FAIL reset_out: got v%b r%b f%b %h %h %h want 0",
                               o_valid, o_ready, o_fault, o_heading, o_roll, o_pitch);
        end
    endtask

    task test_init_and_burst;
        bit ok;
        logic [16:0] exp_seq [8];
        exp_seq = '{{1'b0, 8'h00, 8'h00}, {1'b1, 8'h3D, 8'h0C}, {1'b0, 8'h1A, 8'h00},
                    {1'b0, 8'h1B, 8'h00}, {1'b0, 8'h1C, 8'h00}, {1'b0, 8'h1D, 8'h00},
                    {1'b0, 8'h1E, 8'h00}, {1'b0, 8'h1F, 8'h00}};
        start_run(10, 8'hA0);
        wait_valid(1, 2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_valid_timeout: got no o_valid want one"); end
        repeat (20) @(posedge clk);
        checks++;
        if (log_q.size() != 8) begin
            errors++; $display("FAIL init_req_count: got %0d want 8", log_q.size());
        end
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i][16:8] !== exp_seq[i][16:8] || (i == 1 && log_q[i][7:0] !== 8'h0C)) begin
                errors++; $display("FAIL init_req_order[%0d]: got %h want %h", i, log_q[i], exp_seq[i]);
            end
        end
        checks++;
        if (valid_cnt != 1) begin errors++; $display("FAIL init_valid_once: got %0d want 1", valid_cnt); end
        checks++;
        if ({o_heading, o_roll, o_pitch} !== {16'h0510, 16'hFFF0, 16'h0020}) begin
            errors++; $display("FAIL init_values: got %h %h %h want 0510 fff0 0020",
                               o_heading, o_roll, o_pitch);
        end
        checks++;
        if (o_ready !== 1'b1 || o_fault !== 1'b0) begin
            errors++; $display("FAIL init_ready: got r%b f%b want r1 f0", o_ready, o_fault);
        end
    endtask

    task test_steady_poll;
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (rise1a_q.size() >= 4) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL poll_timeout: got %0d bursts want 4", rise1a_q.size()); end
        for (int k = 0; k + 1 < rise1a_q.size() && k < 3; k++) begin
            checks++;
            if (rise1a_q[k + 1] - rise1a_q[k] != 400) begin
                errors++; $display("FAIL poll_period[%0d]: got %0d want 400", k,
                                   rise1a_q[k + 1] - rise1a_q[k]);
            end
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL poll_stable: got %0d changes want 0", stab_err); end
    endtask

    task test_bad_id;
        bit ok;
        start_run(10, 8'h55);
        wait_fault(1000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL badid_fault: got o_fault=0 want 1"); end
        repeat (600) @(posedge clk);
        checks++;
        if (log_q.size() != 1 || o_req !== 1'b0) begin
            errors++; $display("FAIL badid_no_req: got %0d reqs req=%b want 1 req=0", log_q.size(), o_req);
        end
        checks++;
        if (o_ready !== 1'b0 || o_fault !== 1'b1) begin
            errors++; $display("FAIL badid_flags: got r%b f%b want r0 f1", o_ready, o_fault);
        end
    endtask

    task test_retry;
        bit ok;
        int nlog;
        start_run(10, 8'hA0);
        err_addr = 8'h1C; err_cnt = 2;
        wait_valid(1, 2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL retry_valid_timeout: got no o_valid want one"); end
        checks++;
        if (count_addr(8'h1C) != 3 || count_addr(8'h1A) != 1 || count_addr(8'h1B) != 1
            || log_q.size() != 10) begin
            errors++; $display("FAIL retry_reqs: got 1C=%0d 1A=%0d 1B=%0d total=%0d want 3 1 1 10",
                               count_addr(8'h1C), count_addr(8'h1A), count_addr(8'h1B), log_q.size());
        end
        #1;
        checks++;
        if ({o_heading, o_roll, o_pitch} !== {16'h0510, 16'hFFF0, 16'h0020}) begin
            errors++; $display("FAIL retry_values: got %h %h %h want 0510 fff0 0020",
                               o_heading, o_roll, o_pitch);
        end
        // Second burst carries new data and dies on 0x1D after four NACKs.
        eul[0] = 8'h11; eul[1] = 8'h22; eul[2] = 8'h33;
        eul[3] = 8'h44; eul[4] = 8'h55; eul[5] = 8'h66;
        err_addr = 8'h1D; err_cnt = 4;
        wait_fault(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL retry_fault: got o_fault=0 want 1"); end
        nlog = log_q.size();
        repeat (500) @(posedge clk);
        checks++;
        if (count_addr(8'h1D) != 5 || log_q.size() != nlog || req_in_fault != 0) begin
            errors++; $display("FAIL retry_fault_reqs: got 1D=%0d grow=%0d inf=%0d want 5 0 0",
                               count_addr(8'h1D), log_q.size() - nlog, req_in_fault);
        end
        checks++;
        if ({o_heading, o_roll, o_pitch} !== {16'h0510, 16'hFFF0, 16'h0020}
            || valid_cnt != 1 || o_ready !== 1'b0) begin
            errors++; $display("FAIL retry_hold: got %h %h %h v=%0d r=%b want 0510 fff0 0020 1 0",
                               o_heading, o_roll, o_pitch, valid_cnt, o_ready);
        end
    endtask

    task test_overrun;
        bit ok;
        start_run(300, 8'hA0);
        wait_valid(3, 12000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overrun_timeout: got %0d valids want 3", valid_cnt); end
        repeat (5) @(posedge clk);
        for (int k = 0; k < 3 && k + 1 < rise1a_q.size() && k < valid_q.size(); k++) begin
            checks++;
            if (rise1a_q[k + 1] - valid_q[k] < 1 || rise1a_q[k + 1] - valid_q[k] > 2) begin
                errors++; $display("FAIL overrun_restart[%0d]: got %0d cycles want 1..2", k,
                                   rise1a_q[k + 1] - valid_q[k]);
            end
        end
        checks++;
        if (count_addr(8'h1A) != 4 || count_addr(8'h1F) != 3 || valid_cnt != 3) begin
            errors++; $display("FAIL overrun_count: got 1A=%0d 1F=%0d v=%0d want 4 3 3",
                               count_addr(8'h1A), count_addr(8'h1F), valid_cnt);
        end
    endtask

    task test_reset_midread;
        bit ok;
        start_run(20, 8'hA0);
        wait_valid(1, 2000, ok);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (o_req && o_addr == 8'h1D && valid_cnt == 1) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_reach: got no 0x1D read in burst 2 want one"); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_req, o_ready, o_valid, o_heading, o_roll, o_pitch} !== 51'd0) begin
            errors++; $display("FAIL midrst_async: got q%b r%b v%b %h %h %h want 0",
                               o_req, o_ready, o_valid, o_heading, o_roll, o_pitch);
        end
        repeat (3) @(posedge clk);
        log_q.delete(); rise_cyc_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        rel_cyc = cyc;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (log_q.size() >= 1) begin ok = 1; break; end
        end
        checks++;
        if (!ok || log_q[0][16:8] !== {1'b0, 8'h00} || rise_cyc_q[0] - rel_cyc < 100) begin
            errors++; $display("FAIL midrst_reboot: got ok=%b cmd=%h after %0d want rd 00 after >=100",
                               ok, ok ? log_q[0] : 17'd0, ok ? rise_cyc_q[0] - rel_cyc : 0);
        end
    endtask

    initial begin
        test_reset();
        test_init_and_burst();
        test_steady_poll();
        test_bad_id();
        test_retry();
        test_overrun();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
